t_spi_master: RTL and testbench

Parametrised SPI master transmitter/receiver for the FPGA verification harness. It serialises a DATA_W-bit word on spi_o and samples spi_i into a receive word, with configurable SCLK divider, SPI mode (CPOL/CPHA) and bit order. A valid/ready handshake allows back-to-back words inside one chip-select frame. It sits between a harness stimulus source (memory/ROM read port) and the SPI pins of the DUT.

---
 rtl/t_spi_master.sv | 153 +++++++++++++++
 tb/tb_t_spi_master.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/t_spi_master.sv
// SPI master: serialises one DATA_W word per request on spi_o and assembles spi_i into rx_data_o.
// Latency: first SCLK edge 1+CLK_DIV cycles after accept, rx_valid_o at 1+CLK_DIV*(2*DATA_W+1).
// Backpressure: ready_o only in IDLE/HOLD; req_i is ignored while a word or the CS hold is in flight.
module t_spi_master #(
  parameter int DATA_W  = 32,
  parameter int CLK_DIV = 1,
  parameter bit CPOL    = 1'b1,
  parameter bit CPHA    = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              req_i,
  input  logic              last_i,
  input  logic              lsb_first_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              spi_o,
  input  logic              spi_i,
  output logic              spi_clk,
  output logic              spi_cs
);

  localparam int DIV_W  = $clog2(CLK_DIV + 1);
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST  = EDGE_W'(2 * DATA_W);
  localparam logic [EDGE_W-1:0] EDGE_FINAL = EDGE_W'(2 * DATA_W - 1);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, HOLD, TRAIL} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [DIV_W-1:0]   div_cnt;
  logic [EDGE_W-1:0]  edge_cnt;
  logic [DATA_W-1:0]  tx_sr;
  logic [DATA_W-1:0]  rx_sr;
  logic               lsb_first;
  logic               last;

  logic               accept;
  logic               div_end;
  logic               last_half;
  logic               final_trail;
  logic               edge_go;
  logic               lead_edge;
  logic               do_sample;
  logic               do_shift;
  logic               word_done;

  // Next bit to drive for the chosen bit order
  function automatic logic pick_bit(input logic [DATA_W-1:0] d, input logic lsb);
    return lsb ? d[0] : d[DATA_W-1];
  endfunction

  // Shift register advance matching pick_bit
  function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] d, input logic lsb);
    return lsb ? (d >> 1) : (d << 1);
  endfunction

  assign ready_o     = (state == IDLE) || (state == HOLD);
  assign busy_o      = (state != IDLE);
  assign accept      = req_i && ready_o;
  assign div_end     = (div_cnt == DIV_LAST);
  assign last_half   = (edge_cnt == EDGE_LAST);
  assign final_trail = (edge_cnt == EDGE_FINAL);
  assign word_done   = (state == SHIFT) && div_end && last_half;

  // An SCLK edge starts every half-period: leaving LEAD, and each SHIFT boundary but the last.
  assign edge_go   = div_end && ((state == LEAD) || ((state == SHIFT) && !last_half));
  // The half-period being entered is edge_cnt+1; odd numbers are leading edges.
  assign lead_edge = ~edge_cnt[0];
  assign do_sample = edge_go && (lead_edge ^ CPHA);
  assign do_shift  = edge_go && (CPHA ? lead_edge : (!lead_edge && !final_trail));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)  state_nxt = LEAD;
      LEAD:    if (div_end) state_nxt = SHIFT;
      SHIFT:   if (div_end && last_half) state_nxt = last ? TRAIL : HOLD;
      HOLD:    if (accept)  state_nxt = LEAD;
      TRAIL:   if (div_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Half-period divider and edge counter, both restarted on every state entry
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
    end else begin
      if ((state_nxt != state) || div_end || (state == IDLE) || (state == HOLD)) div_cnt <= '0;
      else div_cnt <= div_cnt + 1'b1;
      if (edge_go)                 edge_cnt <= edge_cnt + 1'b1;
      else if (state_nxt != state) edge_cnt <= '0;
    end
  end

  // SPI pins, shift registers and receive handoff
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      spi_cs     <= 1'b1;
      spi_clk    <= CPOL;
      spi_o      <= 1'b0;
      rx_valid_o <= 1'b0;
      rx_data_o  <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      lsb_first  <= 1'b0;
      last       <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;
      if (accept) begin
        lsb_first <= lsb_first_i;
        last      <= last_i;
        spi_cs    <= 1'b0;
        // CPHA=0 must present the first bit before the first leading edge.
        if (!CPHA) begin
          spi_o <= pick_bit(tx_data_i, lsb_first_i);
          tx_sr <= shift_word(tx_data_i, lsb_first_i);
        end else begin
          tx_sr <= tx_data_i;
        end
      end
      if (edge_go) spi_clk <= ~spi_clk;
      if (do_shift) begin
        spi_o <= pick_bit(tx_sr, lsb_first);
        tx_sr <= shift_word(tx_sr, lsb_first);
      end
      if (do_sample) begin
        rx_sr <= lsb_first ? {spi_i, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], spi_i};
      end
      if (word_done) begin
        spi_clk    <= CPOL;
        rx_data_o  <= rx_sr;
        rx_valid_o <= 1'b1;
      end
      if ((state == TRAIL) && div_end) spi_cs <= 1'b1;
    end
  end

endmodule

// File: tb/tb_t_spi_master.sv
// Bench for t_spi_master: default instance in loopback, small CPHA=1 instance with a slave model.
// Expected rx words go through per-instance scoreboard queues popped on rx_valid_o.
// Directed sequence: reset, reset mid-word, timing, mode/order, back-to-back, held request.
module tb_t_spi_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance 0: defaults (32 bit, CLK_DIV=1, CPOL=1, CPHA=0), MISO looped to MOSI
  logic [31:0] data0 = '0;
  logic        req0 = 1'b0, last0 = 1'b0, lsb0 = 1'b0;
  logic        ready0, busy0, rxv0, so0, si0, sck0, cs0;
  logic [31:0] rxd0;
  assign si0 = so0;

  // instance 1: 8 bit, CLK_DIV=3, CPOL=0, CPHA=1, MISO driven by the slave model
  logic [7:0]  data1 = '0;
  logic        req1 = 1'b0, last1 = 1'b0, lsb1 = 1'b0;
  logic        ready1, busy1, rxv1, so1, sck1, cs1;
  logic        si1 = 1'b0;
  logic [7:0]  rxd1;

  t_spi_master u0 (
    .clk_i(clk), .rst_i(rst), .tx_data_i(data0), .req_i(req0), .last_i(last0),
    .lsb_first_i(lsb0), .ready_o(ready0), .busy_o(busy0), .rx_data_o(rxd0),
    .rx_valid_o(rxv0), .spi_o(so0), .spi_i(si0), .spi_clk(sck0), .spi_cs(cs0)
  );

  t_spi_master #(.DATA_W(8), .CLK_DIV(3), .CPOL(1'b0), .CPHA(1'b1)) u1 (
    .clk_i(clk), .rst_i(rst), .tx_data_i(data1), .req_i(req1), .last_i(last1),
    .lsb_first_i(lsb1), .ready_o(ready1), .busy_o(busy1), .rx_data_o(rxd1),
    .rx_valid_o(rxv1), .spi_o(so1), .spi_i(si1), .spi_clk(sck1), .spi_cs(cs1)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboards
  logic [31:0] q0[$];
  logic [7:0]  q1[$];
  logic        mosi1[$];

  // monitor state (written only by the monitors)
  int          acc0 = 0, rxn0 = 0, rise0 = 0, hold0 = 0, lead0 = 0;
  logic [31:0] mosi0_word = '0;
  logic        cs0_prev = 1'b1, sck0_prev = 1'b1;
  int          cyc = 0, lead1 = 0, last_rise1 = -1, period1 = 0, sbit = 0;
  logic        sck1_prev = 1'b0;
  logic [7:0]  slave_word = 8'h3C;

  // instance 0 monitor: accepts, scoreboard pop, CS rises, HOLD cycles, SCLK leading edges
  always @(negedge clk) begin
    if (req0 && ready0) acc0++;
    if (busy0 && ready0) hold0++;
    if (rxv0) begin
      rxn0++;
      if (q0.size() == 0) check("rx0_pending", q0.size(), 1);
      else check("rx0_data", rxd0, q0.pop_front());
    end
    if (cs0 && !cs0_prev) rise0++;
    if (sck0_prev && !sck0) begin
      lead0++;
      mosi0_word = {mosi0_word[30:0], so0};
    end
    cs0_prev  = cs0;
    sck0_prev = sck0;
  end

  // instance 1 monitor and slave: drive MISO on leading (rising) edge, capture MOSI on trailing
  always @(negedge clk) begin
    cyc++;
    if (rxv1) begin
      if (q1.size() == 0) check("rx1_pending", q1.size(), 1);
      else check("rx1_data", rxd1, q1.pop_front());
    end
    if (!sck1_prev && sck1) begin
      lead1++;
      if (last_rise1 >= 0) period1 = cyc - last_rise1;
      last_rise1 = cyc;
      if (sbit < 8) si1 = slave_word[sbit];
      sbit++;
    end
    if (sck1_prev && !sck1) mosi1.push_back(so1);
    if (cs1) sbit = 0;
    sck1_prev = sck1;
  end

  // present a word on instance 0; returns just after the accepting edge (cycle 1)
  task automatic send0(input logic [31:0] d, input logic lst, input logic lsb, input bit push);
    @(posedge clk); #1;
    data0 = d; last0 = lst; lsb0 = lsb; req0 = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready0) break;
    end
    if (!ready0) check("ready0_timeout", ready0, 1);
    if (push) q0.push_back(d);
    @(posedge clk); #1;
    req0 = 1'b0;
  endtask

  // wait on instance 0: sel 0 = rx_valid_o, 1 = spi_cs high, 2 = ready_o
  task automatic wait0(input int sel, input string tag);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      hit = (sel == 0) ? rxv0 : (sel == 1) ? cs0 : ready0;
    end
    if (!hit) check(tag, hit, 1);
  endtask

  int c, rxc, csc, snap_acc, snap_rx, snap_rise, snap_hold, snap_lead;
  logic sck_c2;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_cs0", cs0, 1);
    check("rst_sck0", sck0, 1);
    check("rst_mosi0", so0, 0);
    check("rst_ready0", ready0, 1);
    check("rst_busy0", busy0, 0);
    check("rst_rxv0", rxv0, 0);
    check("rst_rxd0", rxd0, 0);
    check("rst_sck1", sck1, 0);
    check("rst_cs1", cs1, 1);

    // reset in the middle of a word: discarded, no rx_valid_o
    snap_rx = rxn0;
    send0(32'hA5A5A5A5, 1'b1, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    check("mid_busy0", busy0, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mrst_cs0", cs0, 1);
    check("mrst_sck0", sck0, 1);
    check("mrst_ready0", ready0, 1);
    check("mrst_busy0", busy0, 0);
    check("mrst_rxv0", rxv0, 0);
    repeat (80) @(negedge clk);
    #1 check("mrst_no_rx", rxn0, snap_rx);

    // 0xDEADBEEF, MSB first, last word: cycle-exact timing
    snap_lead = lead0;
    send0(32'hDEADBEEF, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("c1_cs0", cs0, 0);
    check("c1_sck0", sck0, 1);
    check("c1_mosi0", so0, 1);
    check("c1_ready0", ready0, 0);
    c = 1; rxc = -1; csc = -1; sck_c2 = 1'b1;
    while (c < 200 && csc < 0) begin
      @(negedge clk);
      c++;
      if (c == 2) sck_c2 = sck0;
      if (rxv0 && rxc < 0) rxc = c;
      if (cs0 && csc < 0) csc = c;
    end
    check("dbf_first_edge", sck_c2, 0);
    check("dbf_rx_cycle", rxc, 66);
    check("dbf_cs_cycle", csc, 67);
    #1;
    check("dbf_sclk_pulses", lead0 - snap_lead, 32);
    check("dbf_mosi_stream", mosi0_word, 32'hDEADBEEF);

    // instance 1: CPOL=0 CPHA=1 CLK_DIV=3, 0x81 LSB first, slave returns 0x3C
    @(posedge clk); #1;
    data1 = 8'h81; last1 = 1'b1; lsb1 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    check("u1_ready", ready1, 1);
    q1.push_back(8'h3C);
    @(posedge clk); #1;
    req1 = 1'b0;
    data1 = 8'hFF;
    c = 1; rxc = -1; csc = -1;
    @(negedge clk);
    while (c < 200 && csc < 0) begin
      if (rxv1 && rxc < 0) rxc = c;
      if (cs1 && csc < 0) csc = c;
      if (csc < 0) begin
        @(negedge clk);
        c++;
      end
    end
    check("u1_rx_cycle", rxc, 52);
    check("u1_cs_cycle", csc, 55);
    #1;
    check("u1_sclk_period", period1, 6);
    check("u1_sclk_pulses", lead1, 8);
    check("u1_mosi_count", mosi1.size(), 8);
    for (int i = 0; i < 8 && mosi1.size() > 0; i++) begin
      logic [7:0] exp_bits;
      exp_bits = 8'h81;
      check($sformatf("u1_mosi_bit%0d", i), mosi1.pop_front(), exp_bits[i]);
    end

    // back-to-back words in one frame, HOLD of 5 cycles
    snap_rise = rise0; snap_rx = rxn0; snap_hold = hold0;
    send0(32'h12345678, 1'b0, 1'b0, 1'b1);
    wait0(0, "b2b_rx_timeout");
    check("b2b_hold_cs0", cs0, 0);
    check("b2b_hold_ready0", ready0, 1);
    repeat (3) @(negedge clk);
    send0(32'h9ABCDEF0, 1'b1, 1'b0, 1'b1);
    wait0(1, "b2b_cs_timeout");
    #1;
    check("b2b_cs_rises", rise0 - snap_rise, 1);
    check("b2b_rx_pulses", rxn0 - snap_rx, 2);
    check("b2b_hold_cycles", hold0 - snap_hold, 5);

    // req_i held high: one accept per ready window, data captured at the accept cycle
    snap_acc = acc0;
    @(posedge clk); #1;
    data0 = 32'hCAFEF00D; last0 = 1'b1; lsb0 = 1'b0; req0 = 1'b1;
    wait0(2, "held_ready_timeout");
    q0.push_back(32'hCAFEF00D);
    @(posedge clk); #1;
    data0 = 32'h0BADC0DE;
    wait0(0, "held_rx_timeout");
    #1 check("held_single_accept", acc0 - snap_acc, 1);
    wait0(2, "held_idle_timeout");
    q0.push_back(32'h0BADC0DE);
    @(posedge clk); #1;
    req0 = 1'b0;
    wait0(0, "held_rx2_timeout");
    wait0(1, "held_cs_timeout");
    #1 check("held_two_accepts", acc0 - snap_acc, 2);

    repeat (5) @(negedge clk);
    #1;
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
